// File: rtl/instr_sequencer_if.sv
// Handshake/strobe bundle between the sequencer and its datapath.
// Master: datapath side (drives decode/ack, receives strobes). Slave: sequencer.
interface instr_sequencer_if #(
   parameter int INSTR_W = 9,
   parameter int CNT_W   = 16
);
   logic               start;
   logic [INSTR_W-1:0] instr;
   logic               dec_read_mem;
   logic               dec_write_mem;
   logic               dec_reg_write;
   logic               dec_bne;
   logic               alu_zero;
   logic               mem_ack;
   logic               pc_rst;
   logic               pc_inc;
   logic               pc_branch;
   logic               ir_load;
   logic               reg_we;
   logic               mem_re;
   logic               mem_we;
   logic               busy;
   logic               done;
   logic               err;
   logic [CNT_W-1:0]   instr_count;
   logic [2:0]         state;

   modport master (
      output start, instr, dec_read_mem, dec_write_mem,
      output dec_reg_write, dec_bne, alu_zero, mem_ack,
      input  pc_rst, pc_inc, pc_branch, ir_load, reg_we,
      input  mem_re, mem_we, busy, done, err,
      input  instr_count, state
   );

   modport slave (
      input  start, instr, dec_read_mem, dec_write_mem,
      input  dec_reg_write, dec_bne, alu_zero, mem_ack,
      output pc_rst, pc_inc, pc_branch, ir_load, reg_we,
      output mem_re, mem_we, busy, done, err,
      output instr_count, state
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/execute sequencer for the 9-bit CPU datapath.
// Ports: clk, reset (async high), bus (slave): decode in, strobes/status out.
module instr_sequencer #(
   parameter int                  INSTR_W     = 9,
   parameter logic [INSTR_W-1:0]  HALT_INSTR  = {INSTR_W{1'b1}},
   parameter int                  CNT_W       = 16,
   parameter int                  MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   instr_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      FETCH  = 3'b001,
      DECODE = 3'b010,
      EXEC   = 3'b011,
      MEM    = 3'b100,
      WB     = 3'b101,
      HALT   = 3'b110,
      ERR    = 3'b111
   } state_t;

   // Last no-ack cycle index before the wait is abandoned.
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_tmo;
   logic [CNT_W-1:0] r_cnt;

   logic w_pc_rst;
   logic w_pc_inc;
   logic w_pc_branch;
   logic w_ir_load;
   logic w_reg_we;
   logic w_mem_re;
   logic w_mem_we;
   logic w_clr_cnt;
   logic w_inc_cnt;
   logic w_clr_tmo;
   logic w_inc_tmo;
   logic w_take_br;

   always_comb begin
      w_next      = r_state;
      w_pc_rst    = 1'b0;
      w_pc_inc    = 1'b0;
      w_pc_branch = 1'b0;
      w_ir_load   = 1'b0;
      w_reg_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_we    = 1'b0;
      w_clr_cnt   = 1'b0;
      w_inc_cnt   = 1'b0;
      w_clr_tmo   = 1'b0;
      w_inc_tmo   = 1'b0;
      w_take_br   = 1'b0;
      unique case (r_state)
         IDLE, HALT, ERR: begin
            if (bus.start) begin
               w_pc_rst  = 1'b1;
               w_clr_cnt = 1'b1;
               w_next    = FETCH;
            end
         end
         FETCH: begin
            w_ir_load = 1'b1;
            w_next    = DECODE;
         end
         DECODE: begin
            if (bus.instr == HALT_INSTR)
               w_next = HALT;
            else
               w_next = EXEC;
         end
         EXEC: begin
            if (bus.dec_read_mem || bus.dec_write_mem) begin
               w_clr_tmo = 1'b1;
               w_next    = MEM;
            end else begin
               w_next = WB;
            end
         end
         MEM: begin
            // A store takes priority over a load if both are decoded.
            w_mem_we = bus.dec_write_mem;
            w_mem_re = bus.dec_read_mem & ~bus.dec_write_mem;
            if (bus.mem_ack)
               w_next = WB;
            else if (r_tmo == TMO_LAST)
               w_next = ERR;
            else
               w_inc_tmo = 1'b1;
         end
         WB: begin
            w_reg_we    = bus.dec_reg_write & ~bus.dec_write_mem;
            w_take_br   = bus.dec_bne & ~bus.alu_zero;
            w_pc_branch = w_take_br;
            w_pc_inc    = ~w_take_br;
            w_inc_cnt   = 1'b1;
            w_next      = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_tmo   <= 8'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_clr_tmo)
            r_tmo <= 8'd0;
         else if (w_inc_tmo)
            r_tmo <= r_tmo + 8'd1;
         if (w_clr_cnt)
            r_cnt <= '0;
         else if (w_inc_cnt && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.pc_rst      = w_pc_rst;
   assign bus.pc_inc      = w_pc_inc;
   assign bus.pc_branch   = w_pc_branch;
   assign bus.ir_load     = w_ir_load;
   assign bus.reg_we      = w_reg_we;
   assign bus.mem_re      = w_mem_re;
   assign bus.mem_we      = w_mem_we;
   assign bus.busy        = (r_state != IDLE) && (r_state != HALT)
                            && (r_state != ERR);
   assign bus.done        = (r_state == HALT) || (r_state == ERR);
   assign bus.err         = (r_state == ERR);
   assign bus.instr_count = r_cnt;
   assign bus.state       = r_state;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer.
// Runs with MEM_TIMEOUT=4 and CNT_W=2 to reach timeout and saturation.
module tb_instr_sequencer;
   localparam int CW = 2;

   localparam logic [2:0] S_IDLE = 3'b000;
   localparam logic [2:0] S_FET  = 3'b001;
   localparam logic [2:0] S_DEC  = 3'b010;
   localparam logic [2:0] S_EXE  = 3'b011;
   localparam logic [2:0] S_MEM  = 3'b100;
   localparam logic [2:0] S_WB   = 3'b101;
   localparam logic [2:0] S_HLT  = 3'b110;
   localparam logic [2:0] S_ERR  = 3'b111;

   localparam logic [9:0] P_RST = 10'h200;
   localparam logic [9:0] P_INC = 10'h100;
   localparam logic [9:0] P_BR  = 10'h080;
   localparam logic [9:0] IRL   = 10'h040;
   localparam logic [9:0] RWE   = 10'h020;
   localparam logic [9:0] MRE   = 10'h010;
   localparam logic [9:0] MWE   = 10'h008;
   localparam logic [9:0] BSY   = 10'h004;
   localparam logic [9:0] DN    = 10'h002;
   localparam logic [9:0] ER    = 10'h001;

   logic clk;
   logic reset;

   instr_sequencer_if #(.INSTR_W(9), .CNT_W(CW)) bus ();

   instr_sequencer #(
      .INSTR_W(9),
      .HALT_INSTR(9'h1FF),
      .CNT_W(CW),
      .MEM_TIMEOUT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int c;

   logic [14:0] sb_q[$];
   string       tag_q[$];

   function automatic logic [14:0] obs();
      return {bus.state, bus.pc_rst, bus.pc_inc, bus.pc_branch,
              bus.ir_load, bus.reg_we, bus.mem_re, bus.mem_we,
              bus.busy, bus.done, bus.err, bus.instr_count};
   endfunction

   task automatic push(input string t, input logic [2:0] s,
                       input logic [9:0] strb, input int cnt);
      sb_q.push_back({s, strb, CW'(cnt)});
      tag_q.push_back(t);
   endtask

   task automatic check();
      logic [14:0] e;
      logic [14:0] o;
      string       t;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $error("FAIL sb_empty obs=%h exp=entry", obs());
      end else begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         o = obs();
         assert (o === e) else begin
            n_bad++;
            $error("FAIL %s obs=%h exp=%h", t, o, e);
         end
      end
   endtask

   // One clock cycle: expectation for the current cycle, checked mid-cycle.
   task automatic chk(input string t, input logic [2:0] s,
                      input logic [9:0] strb, input int cnt);
      push(t, s, strb, cnt);
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset             = 1'b1;
      bus.start         = 1'b0;
      bus.instr         = 9'h000;
      bus.dec_read_mem  = 1'b0;
      bus.dec_write_mem = 1'b0;
      bus.dec_reg_write = 1'b0;
      bus.dec_bne       = 1'b0;
      bus.alu_zero      = 1'b0;
      bus.mem_ack       = 1'b0;
      @(posedge clk);
      #1;
      chk("reset", S_IDLE, 10'h000, 0);
      reset = 1'b0;
      chk("idle", S_IDLE, 10'h000, 0);

      bus.start = 1'b1;
      chk("start0", S_IDLE, P_RST, 0);
      bus.start = 1'b0;

      bus.dec_reg_write = 1'b1;
      chk("alu_f", S_FET, IRL | BSY, 0);
      chk("alu_d", S_DEC, BSY, 0);
      chk("alu_e", S_EXE, BSY, 0);
      chk("alu_wb", S_WB, RWE | P_INC | BSY, 0);
      chk("alu_f2", S_FET, IRL | BSY, 1);

      bus.dec_reg_write = 1'b0;
      bus.dec_write_mem = 1'b1;
      chk("st_d", S_DEC, BSY, 1);
      chk("st_e", S_EXE, BSY, 1);
      #1;
      push("mem_pre", S_MEM, MWE | BSY, 1);
      check();
      reset = 1'b1;
      #1;
      push("rst_async", S_IDLE, 10'h000, 0);
      check();
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.dec_write_mem = 1'b0;

      bus.start = 1'b1;
      chk("start1", S_IDLE, P_RST, 0);
      bus.start = 1'b0;
      bus.dec_read_mem  = 1'b1;
      bus.dec_reg_write = 1'b1;
      chk("ld_f", S_FET, IRL | BSY, 0);
      chk("ld_d", S_DEC, BSY, 0);
      chk("ld_e", S_EXE, BSY, 0);
      chk("ld_m1", S_MEM, MRE | BSY, 0);
      chk("ld_m2", S_MEM, MRE | BSY, 0);
      bus.mem_ack = 1'b1;
      chk("ld_m3", S_MEM, MRE | BSY, 0);
      bus.mem_ack = 1'b0;
      chk("ld_wb", S_WB, RWE | P_INC | BSY, 0);
      chk("ld_f2", S_FET, IRL | BSY, 1);

      bus.dec_read_mem  = 1'b0;
      bus.dec_reg_write = 1'b0;
      bus.dec_bne       = 1'b1;
      bus.alu_zero      = 1'b0;
      chk("bt_d", S_DEC, BSY, 1);
      chk("bt_e", S_EXE, BSY, 1);
      chk("bt_wb", S_WB, P_BR | BSY, 1);
      chk("bt_f", S_FET, IRL | BSY, 2);

      bus.alu_zero = 1'b1;
      chk("bn_d", S_DEC, BSY, 2);
      chk("bn_e", S_EXE, BSY, 2);
      chk("bn_wb", S_WB, P_INC | BSY, 2);
      chk("bn_f", S_FET, IRL | BSY, 3);

      bus.dec_bne  = 1'b0;
      bus.alu_zero = 1'b0;
      bus.instr    = 9'h1FF;
      chk("h_d", S_DEC, BSY, 3);
      chk("h_h1", S_HLT, DN, 3);
      chk("h_h2", S_HLT, DN, 3);
      bus.start = 1'b1;
      chk("h_start", S_HLT, P_RST | DN, 3);
      bus.instr = 9'h000;
      chk("h_f_ign", S_FET, IRL | BSY, 0);
      bus.start = 1'b0;

      bus.dec_reg_write = 1'b1;
      c = 0;
      for (int i = 0; i < 5; i++) begin
         chk("sat_d", S_DEC, BSY, c);
         chk("sat_e", S_EXE, BSY, c);
         chk("sat_wb", S_WB, RWE | P_INC | BSY, c);
         c = (c < 3) ? c + 1 : 3;
         chk("sat_f", S_FET, IRL | BSY, c);
      end

      bus.dec_write_mem = 1'b1;
      bus.dec_read_mem  = 1'b1;
      chk("sa_d", S_DEC, BSY, 3);
      chk("sa_e", S_EXE, BSY, 3);
      chk("sa_m1", S_MEM, MWE | BSY, 3);
      chk("sa_m2", S_MEM, MWE | BSY, 3);
      chk("sa_m3", S_MEM, MWE | BSY, 3);
      bus.mem_ack = 1'b1;
      chk("sa_m4", S_MEM, MWE | BSY, 3);
      bus.mem_ack = 1'b0;
      chk("sa_wb", S_WB, P_INC | BSY, 3);
      chk("sa_f", S_FET, IRL | BSY, 3);

      bus.dec_read_mem = 1'b0;
      chk("to_d", S_DEC, BSY, 3);
      chk("to_e", S_EXE, BSY, 3);
      chk("to_m1", S_MEM, MWE | BSY, 3);
      chk("to_m2", S_MEM, MWE | BSY, 3);
      chk("to_m3", S_MEM, MWE | BSY, 3);
      chk("to_m4", S_MEM, MWE | BSY, 3);
      bus.mem_ack = 1'b1;
      chk("to_err", S_ERR, DN | ER, 3);
      bus.mem_ack = 1'b0;
      chk("to_err2", S_ERR, DN | ER, 3);
      bus.dec_write_mem = 1'b0;
      bus.start = 1'b1;
      chk("to_start", S_ERR, P_RST | DN | ER, 3);
      bus.start = 1'b0;
      chk("to_f", S_FET, IRL | BSY, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
